// File: rtl/vga_sprite_renderer.sv
// VGA timing generator with a per-frame latched, filled square sprite over a solid background.
// Optional outline ring on the sprite when SPRITE_BORDER_EN is defined.
module vga_sprite_renderer #(
  parameter int          H_VISIBLE    = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_VISIBLE    = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          SPRITE_SIZE  = 16,
  parameter logic [11:0] SPRITE_COLOR = 12'hF00,
  parameter logic [11:0] BG_COLOR     = 12'h000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic [9:0] obj_x,
  input  logic [9:0] obj_y,
  output logic       hsync,
  output logic       vsync,
  output logic [11:0] rgb,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic       frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [10:0] SZ       = 11'(SPRITE_SIZE);

  logic [9:0]  hcnt, vcnt, lat_x, lat_y;
  logic [9:0]  hcnt_next, vcnt_next;
  logic [10:0] hx, vy, lx, ly;
  logic        latch_pt, visible, hit, hs_n, vs_n;
  logic [11:0] pixel;

  // 11-bit widening keeps lat+SIZE from wrapping, so far-right/bottom positions simply miss.
  assign hx = {1'b0, hcnt};
  assign vy = {1'b0, vcnt};
  assign lx = {1'b0, lat_x};
  assign ly = {1'b0, lat_y};

  assign latch_pt = (hcnt == 10'd0) && (vy == V_VIS);

  always_comb begin
    hcnt_next = (hcnt == H_LAST) ? 10'd0 : hcnt + 10'd1;
    vcnt_next = vcnt;
    if (hcnt == H_LAST) begin
      vcnt_next = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
    end
  end

  always_comb begin
    hs_n    = !((hx >= HS_START) && (hx < HS_END));
    vs_n    = !((vy >= VS_START) && (vy < VS_END));
    visible = (hx < H_VIS) && (vy < V_VIS);
    hit     = (hx >= lx) && (hx < lx + SZ) && (vy >= ly) && (vy < ly + SZ);
    pixel   = 12'h000;
    if (visible) begin
      pixel = BG_COLOR;
      if (hit) begin
        pixel = SPRITE_COLOR;
`ifdef SPRITE_BORDER_EN
        // Ring columns/rows past the screen edge are never visible, so clipped sides show no border.
        if ((hx == lx) || (hx == lx + SZ - 11'd1) || (vy == ly) || (vy == ly + SZ - 11'd1)) begin
          pixel = ~SPRITE_COLOR;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt        <= 10'd0;
      vcnt        <= 10'd0;
      lat_x       <= 10'd0;
      lat_y       <= 10'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb         <= 12'h000;
      px_x        <= 10'd0;
      px_y        <= 10'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        hcnt  <= hcnt_next;
        vcnt  <= vcnt_next;
        hsync <= hs_n;
        vsync <= vs_n;
        rgb   <= pixel;
        px_x  <= hcnt;
        px_y  <= vcnt;
        // First blanking line: safe to swap position without tearing the visible frame.
        if (latch_pt) begin
          lat_x       <= obj_x;
          lat_y       <= obj_y;
          frame_start <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Scoreboard bench for vga_sprite_renderer using shrunken timing so several frames fit in a short run.
// A pixel-index reference model pushes expected outputs; a negedge monitor pops and compares.
module tb_vga_sprite_renderer;
  localparam int HV = 40, HF = 4, HS = 8, HB = 4;
  localparam int VV = 30, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int SZ = 8;
  localparam logic [11:0] SC = 12'hF00;
  localparam logic [11:0] BG = 12'h123;
  localparam int TOTAL_CLKS = 36000;
  localparam int PHASE1_CLKS = 17000;
  localparam int RST_AT = 24000;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [11:0] rgb;
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
  } item_t;

  logic clk = 1'b0;
  logic rst_n, pix_en;
  logic [9:0] obj_x, obj_y;
  logic hsync, vsync, frame_start;
  logic [11:0] rgb;
  logic [9:0] px_x, px_y;

  int n_cmp = 0;
  int n_bad = 0;
  item_t q[$];
  item_t exp_item;
  logic presented;

  int m_n;
  int m_lx, m_ly;

  vga_sprite_renderer #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SPRITE_SIZE(SZ), .SPRITE_COLOR(SC), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .obj_x(obj_x), .obj_y(obj_y),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .px_x(px_x), .px_y(px_y),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_n  = 0;
    m_lx = 0;
    m_ly = 0;
  endtask

  // Pixel n after reset sits at column n mod HT on line (n / HT) mod VT.
  task automatic model_step();
    item_t it;
    int x, y;
    bit vis, hit;
    x = m_n % HT;
    y = (m_n / HT) % VT;
    it.fs = 1'b0;
    if (x == 0 && y == VV) begin
      m_lx = int'(obj_x);
      m_ly = int'(obj_y);
      it.fs = 1'b1;
    end
    it.hs = !(x >= HV + HF && x < HV + HF + HS);
    it.vs = !(y >= VV + VF && y < VV + VF + VS);
    vis = (x < HV) && (y < VV);
    hit = (x >= m_lx) && (x < m_lx + SZ) && (y >= m_ly) && (y < m_ly + SZ);
    it.rgb = 12'h000;
    if (vis) begin
      it.rgb = hit ? SC : BG;
`ifdef SPRITE_BORDER_EN
      if (hit && (x == m_lx || x == m_lx + SZ - 1 || y == m_ly || y == m_ly + SZ - 1))
        it.rgb = ~SC;
`endif
    end
    it.x = 10'(x);
    it.y = 10'(y);
    q.push_back(it);
    m_n++;
  endtask

  task automatic pick_obj();
    case ($urandom_range(0, 8))
      0: begin obj_x = 10'd0;   obj_y = 10'd0;  end
      1: begin obj_x = 10'd10;  obj_y = 10'd5;  end
      2: begin obj_x = 10'(HV - 4); obj_y = 10'(VV - 4); end
      3: begin obj_x = 10'(HV); obj_y = 10'd3;  end
      4: begin obj_x = 10'd3;   obj_y = 10'(VV); end
      5: begin obj_x = 10'd1023; obj_y = 10'd1023; end
      6: begin obj_x = 10'(HV - SZ); obj_y = 10'd0; end
      default: begin
        obj_x = 10'($urandom_range(0, HV + 10));
        obj_y = 10'($urandom_range(0, VV + 6));
      end
    endcase
  endtask

  task automatic chk_reset_vals(input string nm);
    chk(nm, {hsync, vsync, rgb, px_x, px_y, frame_start},
        {1'b1, 1'b1, 12'h000, 10'd0, 10'd0, 1'b0});
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) presented <= 1'b0;
    else        presented <= pix_en;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (presented) begin
        if (q.size() == 0) begin
          chk("queue_underflow", 32'd0, 32'd1);
        end else begin
          exp_item = q.pop_front();
          if (n_cmp < 200 || exp_item.fs || (exp_item.x == 10'd0 && exp_item.y == 10'd0))
            $display("px (%0d,%0d) rgb=%03h hs=%0b vs=%0b fs=%0b", px_x, px_y, rgb, hsync, vsync, frame_start);
          chk("pixel", {hsync, vsync, rgb, px_x, px_y, frame_start}, exp_item);
        end
      end else begin
        chk("frame_start_idle", {31'd0, frame_start}, 32'd0);
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    pix_en = 1'b0;
    obj_x  = 10'd10;
    obj_y  = 10'd5;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals("reset_initial");
    rst_n = 1'b1;
    for (int c = 0; c < TOTAL_CLKS; c++) begin
      @(negedge clk);
      if (c == RST_AT) begin
        #2 rst_n = 1'b0;
        pix_en = 1'b0;
        #1 chk_reset_vals("reset_async");
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
      end
      if ($urandom_range(0, 399) == 0) pick_obj();
      if (c < PHASE1_CLKS) pix_en = (c % 4 == 0);
      else                 pix_en = ($urandom_range(0, 2) != 0);
      if (pix_en) model_step();
    end
    @(negedge clk);
    pix_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
